// File: rtl/ccff_pkg.sv
// ---------------------------------------------------------------------------
// ccff_pkg
// Shared definitions for the configuration-chain loader:
//   - ccff_state_e : loader FSM states (IDLE, LOAD, DONE)
//   - ccff_words() : ceiling division, words needed to cover a chain
//   - ccff_cnt_w() : width of a counter that must hold 0..max_val
//   - default parameter values and the counter widths they imply
// ---------------------------------------------------------------------------
package ccff_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } ccff_state_e;

   function automatic int ccff_words(input int len, input int w);
      return (len + w - 1) / w;
   endfunction

   // A counter holding 0..max_val; never narrower than one bit.
   function automatic int ccff_cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   localparam int CCFF_DEF_WORD_W    = 8;
   localparam int CCFF_DEF_CHAIN_LEN = 16;
   localparam int CCFF_DEF_BIT_CNT_W = $clog2(CCFF_DEF_CHAIN_LEN + 1);
   localparam int CCFF_DEF_BUF_CNT_W = $clog2(CCFF_DEF_WORD_W + 1);

endpackage

// File: rtl/ccff_rb_deser.sv
// ---------------------------------------------------------------------------
// ccff_rb_deser
// Readback serial-to-parallel converter. Each strobed tail bit is written
// MSB-down into the word under assembly. When WORD_W bits have been
// collected, or the strobed bit is flagged as the last of the load, the
// word is published on rb_data with a one-cycle rb_valid pulse in the next
// cycle. A short final word is zero-padded in its low bits.
//
// Ports:
//   prog_clk  in   clock, rising edge
//   pReset_n  in   asynchronous active-low reset
//   sample    in   capture tail at this edge
//   tail      in   serial bit from the chain tail
//   last      in   this sample is the final one of the load (flush)
//   rb_data   out  WORD_W readback word, first bit in MSB
//   rb_valid  out  one-cycle pulse, rb_data is new
// ---------------------------------------------------------------------------
module ccff_rb_deser
   import ccff_pkg::*;
#(
   parameter int WORD_W = CCFF_DEF_WORD_W
) (
   input  logic              prog_clk,
   input  logic              pReset_n,
   input  logic              sample,
   input  logic              tail,
   input  logic              last,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid
);

   localparam int                IDX_W    = ccff_cnt_w(WORD_W - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WORD_W - 1);

   logic [IDX_W-1:0]  idx_q;
   logic [WORD_W-1:0] acc_q;
   logic [WORD_W-1:0] acc_nxt;

   // Starting a new word clears stale bits, so a flushed partial word has
   // zeros below the bits actually captured.
   always_comb begin
      acc_nxt = (idx_q == '0) ? '0 : acc_q;
      acc_nxt[IDX_LAST - idx_q] = tail;
   end

   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         idx_q    <= '0;
         acc_q    <= '0;
         rb_data  <= '0;
         rb_valid <= 1'b0;
      end else begin
         rb_valid <= 1'b0;
         if (sample) begin
            if ((idx_q == IDX_LAST) || last) begin
               rb_data  <= acc_nxt;
               rb_valid <= 1'b1;
               acc_q    <= '0;
               idx_q    <= '0;
            end else begin
               acc_q <= acc_nxt;
               idx_q <= idx_q + IDX_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader
// Serial bitstream writer for a configuration chain. Words arrive over a
// valid/ready stream and are shifted MSB-first into the chain head, one bit
// per enable cycle. ccff_clk_en drives an external clock gate; the chain
// shifts on the edge that ends each enable cycle, and the bit leaving the
// chain tail is captured at that same edge and returned as readback words.
//
// Ports:
//   prog_clk     in   configuration clock, rising edge
//   pReset_n     in   asynchronous active-low reset
//   start        in   begin a load (honoured only in IDLE)
//   word_data    in   configuration word, MSB shifted first
//   word_valid   in   word_data valid
//   word_ready   out  loader can accept a word this cycle
//   ccff_head    out  registered serial bit to the chain head
//   ccff_clk_en  out  registered enable for the chain clock gate
//   ccff_tail    in   serial bit from the chain tail
//   rb_data      out  readback word, first bit out in MSB
//   rb_valid     out  one-cycle readback pulse, no backpressure
//   busy         out  load in progress (LOAD or DONE)
//   done         out  one-cycle pulse after the last bit reached the chain
//   dbg_state    out  current FSM state (ccff_state_e encoding)
//
// Handshake: a word transfers on every rising edge where word_valid and
// word_ready are both high. word_ready does not depend on word_valid. A
// producer that raises word_valid must hold it and word_data stable until
// the transfer; word_valid outside LOAD is never accepted.
// ---------------------------------------------------------------------------
module ccff_chain_loader
   import ccff_pkg::*;
#(
   parameter int WORD_W    = CCFF_DEF_WORD_W,
   parameter int CHAIN_LEN = CCFF_DEF_CHAIN_LEN
) (
   input  logic              prog_clk,
   input  logic              pReset_n,
   input  logic              start,
   input  logic [WORD_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              ccff_head,
   output logic              ccff_clk_en,
   input  logic              ccff_tail,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid,
   output logic              busy,
   output logic              done,
   output logic [1:0]        dbg_state
);

   localparam int N_WORDS    = ccff_words(CHAIN_LEN, WORD_W);
   localparam int BIT_CNT_W  = ccff_cnt_w(CHAIN_LEN);
   localparam int BUF_CNT_W  = ccff_cnt_w(WORD_W);
   localparam int WORD_CNT_W = ccff_cnt_w(N_WORDS);

   localparam logic [BIT_CNT_W-1:0]  CHAIN_LEN_C = BIT_CNT_W'(CHAIN_LEN);
   localparam logic [WORD_CNT_W-1:0] N_WORDS_C   = WORD_CNT_W'(N_WORDS);
   localparam logic [BUF_CNT_W-1:0]  BUF_REFILL  = BUF_CNT_W'(WORD_W - 1);

   ccff_state_e state_q, state_nxt;

   // buf_q holds bits of the current word not yet placed on ccff_head,
   // left-aligned so the next bit is always buf_q[WORD_W-1].
   logic [WORD_W-1:0]     buf_q;
   logic [BUF_CNT_W-1:0]  buf_cnt_q;
   logic [BIT_CNT_W-1:0]  bits_left_q;   // chain bits still to present
   logic [WORD_CNT_W-1:0] words_acc_q;   // words accepted this load
   logic                  head_q;
   logic                  en_q;

   logic start_load;
   logic accept;
   logic pop;
   logic last_sample;

   // ---------------- FSM ----------------
   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) state_q <= ST_IDLE;
      else           state_q <= state_nxt;
   end

   // LOAD ends once every chain bit has been presented; the last one is on
   // ccff_head in the cycle where bits_left_q first reads zero.
   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         ST_IDLE: if (start) state_nxt = ST_LOAD;
         ST_LOAD: if (bits_left_q == '0) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- handshake / shift control ----------------
   // Ready whenever the buffer holds no unpresented bits: either it is empty
   // or its final bit is on ccff_head now. A word accepted at that edge
   // presents its MSB directly, sustaining one bit per cycle.
   assign start_load = (state_q == ST_IDLE) && start;
   assign word_ready = (state_q == ST_LOAD) && (words_acc_q < N_WORDS_C) &&
                       (buf_cnt_q == '0) && (bits_left_q != '0);
   assign accept     = word_valid && word_ready;
   assign pop        = (state_q == ST_LOAD) && (buf_cnt_q != '0) &&
                       (bits_left_q != '0);

   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         buf_q       <= '0;
         buf_cnt_q   <= '0;
         bits_left_q <= '0;
         words_acc_q <= '0;
         head_q      <= 1'b0;
         en_q        <= 1'b0;
      end else if (start_load) begin
         buf_q       <= '0;
         buf_cnt_q   <= '0;
         bits_left_q <= CHAIN_LEN_C;
         words_acc_q <= '0;
         en_q        <= 1'b0;
      end else if (accept) begin
         head_q      <= word_data[WORD_W-1];
         buf_q       <= word_data << 1;
         buf_cnt_q   <= BUF_REFILL;
         bits_left_q <= bits_left_q - BIT_CNT_W'(1);
         words_acc_q <= words_acc_q + WORD_CNT_W'(1);
         en_q        <= 1'b1;
      end else if (pop) begin
         head_q      <= buf_q[WORD_W-1];
         buf_q       <= buf_q << 1;
         buf_cnt_q   <= buf_cnt_q - BUF_CNT_W'(1);
         bits_left_q <= bits_left_q - BIT_CNT_W'(1);
         en_q        <= 1'b1;
      end else begin
         // Starved or finished: no shift, head holds its last value.
         en_q <= 1'b0;
         if (state_q == ST_DONE) begin
            // Surplus low bits of a final partial word are dropped here.
            buf_q     <= '0;
            buf_cnt_q <= '0;
         end
      end
   end

   // The edge ending an enable cycle both shifts the chain and captures the
   // old tail bit; the final presented bit marks the readback flush.
   assign last_sample = en_q && (bits_left_q == '0);

   ccff_rb_deser #(
      .WORD_W (WORD_W)
   ) u_rb_deser (
      .prog_clk (prog_clk),
      .pReset_n (pReset_n),
      .sample   (en_q),
      .tail     (ccff_tail),
      .last     (last_sample),
      .rb_data  (rb_data),
      .rb_valid (rb_valid)
   );

   assign ccff_head   = head_q;
   assign ccff_clk_en = en_q;
   assign busy        = (state_q == ST_LOAD) || (state_q == ST_DONE);
   assign done        = (state_q == ST_DONE);
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_chain_loader
// Two loaders share the stimulus: instance A drives a 16-flop chain model,
// instance B a 12-flop one; sel picks which one the driver talks to and
// which outputs are observed. Each chain model is a shift register clocked
// through a latch-based clock-gate model.
// Cycle numbering: cycle 0 is the cycle in which start is high.
// ---------------------------------------------------------------------------
module tb_ccff_chain_loader;
   import ccff_pkg::*;

   localparam int W     = 8;
   localparam int LEN_A = 16;
   localparam int LEN_B = 12;

   // ---------------- clock / reset ----------------
   logic prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   logic         pReset_n;
   logic         start;
   logic         sel;
   logic         word_valid;
   logic [W-1:0] word_data;

   logic start_a, start_b;
   assign start_a = start && !sel;
   assign start_b = start &&  sel;

   logic         ready_a, head_a, en_a, tail_a, rbv_a, busy_a, done_a;
   logic [W-1:0] rb_a;
   logic [1:0]   st_a;
   logic         ready_b, head_b, en_b, tail_b, rbv_b, busy_b, done_b;
   logic [W-1:0] rb_b;
   logic [1:0]   st_b;

   ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(LEN_A)) dut_a (
      .prog_clk (prog_clk), .pReset_n (pReset_n), .start (start_a),
      .word_data (word_data), .word_valid (word_valid), .word_ready (ready_a),
      .ccff_head (head_a), .ccff_clk_en (en_a), .ccff_tail (tail_a),
      .rb_data (rb_a), .rb_valid (rbv_a), .busy (busy_a), .done (done_a),
      .dbg_state (st_a)
   );

   ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(LEN_B)) dut_b (
      .prog_clk (prog_clk), .pReset_n (pReset_n), .start (start_b),
      .word_data (word_data), .word_valid (word_valid), .word_ready (ready_b),
      .ccff_head (head_b), .ccff_clk_en (en_b), .ccff_tail (tail_b),
      .rb_data (rb_b), .rb_valid (rbv_b), .busy (busy_b), .done (done_b),
      .dbg_state (st_b)
   );

   // ---------------- chain models behind a latch ICG ----------------
   logic             en_lat_a, en_lat_b;
   logic [LEN_A-1:0] chain_a = '0;
   logic [LEN_B-1:0] chain_b = '0;

   always_latch if (!prog_clk) en_lat_a = en_a;
   always_latch if (!prog_clk) en_lat_b = en_b;

   always @(posedge prog_clk) if (en_lat_a) chain_a <= {chain_a[LEN_A-2:0], head_a};
   always @(posedge prog_clk) if (en_lat_b) chain_b <= {chain_b[LEN_B-2:0], head_b};

   assign tail_a = chain_a[LEN_A-1];
   assign tail_b = chain_b[LEN_B-1];

   // ---------------- observed outputs ----------------
   logic         o_ready, o_head, o_en, o_rbv, o_busy, o_done;
   logic [W-1:0] o_rb;
   logic [1:0]   o_state;
   logic [15:0]  o_chain;

   assign o_ready = sel ? ready_b : ready_a;
   assign o_head  = sel ? head_b  : head_a;
   assign o_en    = sel ? en_b    : en_a;
   assign o_rbv   = sel ? rbv_b   : rbv_a;
   assign o_busy  = sel ? busy_b  : busy_a;
   assign o_done  = sel ? done_b  : done_a;
   assign o_rb    = sel ? rb_b    : rb_a;
   assign o_state = sel ? st_b    : st_a;
   assign o_chain = sel ? {4'h0, chain_b} : chain_a;

   // ---------------- scoreboard ----------------
   int           n_checks = 0;
   int           n_pass   = 0;
   logic [W-1:0] exp_q[$];
   int           exp_cyc_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic         sel;          // 0: 16-bit chain, 1: 12-bit chain
      logic [W-1:0] w0, w1;
      int           pre;          // ready cycles with valid low before word 0
      int           mid;          // ready cycles with valid low before word 1
      int           spur;         // cycle of an extra start pulse (0: none)
      int           nbits;        // bits expected on the chain head
      logic [15:0]  exp_bits;     // presented bits, first in bit 15
      logic [15:0]  exp_chain;    // chain content after the load
      logic         check_rb;
      logic [W-1:0] rb0, rb1;
      logic         abort_before; // run the mid-load reset sequence first
   } vec_t;

   vec_t vecs[8];

   // ---------------- driver tasks ----------------
   task automatic run_vec(input int r, input vec_t v);
      logic [W-1:0] words[2];
      logic [15:0]  snap[64];
      int widx     = 0;
      int pre_left = v.pre;
      int mid_left = v.mid;
      int en_cnt   = 0;
      int done_cyc = -1;
      int last_cyc = 0;
      int done_exp = 2 + v.pre + v.mid + v.nbits;
      int exp_c;
      words[0] = v.w0;
      words[1] = v.w1;
      exp_q.delete();
      exp_cyc_q.delete();
      if (v.check_rb) begin
         exp_q.push_back(v.rb0); exp_cyc_q.push_back(10 + v.pre);
         exp_q.push_back(v.rb1); exp_cyc_q.push_back(done_exp);
      end
      sel = v.sel;
      @(negedge prog_clk);
      check($sformatf("r%0d_idle_before", r), o_state, ST_IDLE);
      start = 1'b1;
      for (int cyc = 1; cyc < 60 && done_cyc < 0; cyc++) begin
         @(negedge prog_clk);
         last_cyc  = cyc;
         start     = (cyc == v.spur);
         snap[cyc] = o_chain;
         if (cyc == 1) begin
            check($sformatf("r%0d_busy_c1", r), o_busy, 1);
            check($sformatf("r%0d_ready_c1", r), o_ready, 1);
         end
         if (o_en) begin
            exp_c = 2 + v.pre + en_cnt + ((en_cnt >= W) ? v.mid : 0);
            check($sformatf("r%0d_en_cyc%0d", r, en_cnt), cyc, exp_c);
            if (en_cnt < 16)
               check($sformatf("r%0d_head%0d", r, en_cnt), o_head, v.exp_bits[15-en_cnt]);
            en_cnt++;
         end
         if (o_rbv && v.check_rb) begin
            if (exp_q.size() == 0) check($sformatf("r%0d_rb_extra", r), 1, 0);
            else begin
               check($sformatf("r%0d_rb_data", r), o_rb, exp_q.pop_front());
               check($sformatf("r%0d_rb_cyc", r), cyc, exp_cyc_q.pop_front());
            end
         end
         if (o_done) done_cyc = cyc;
         // Valid is raised only against an observed ready, so it never
         // drops without a transfer.
         word_valid = 1'b0;
         if (widx < 2 && o_ready) begin
            if (widx == 0 && pre_left > 0) pre_left--;
            else if (widx == 1 && mid_left > 0) mid_left--;
            else begin
               word_valid = 1'b1;
               word_data  = words[widx];
               widx++;
            end
         end
      end
      if (done_cyc < 0) check($sformatf("r%0d_done_timeout", r), 0, 1);
      check($sformatf("r%0d_done_cyc", r), done_cyc, done_exp);
      check($sformatf("r%0d_en_count", r), en_cnt, v.nbits);
      check($sformatf("r%0d_chain", r), o_chain, v.exp_chain);
      if (v.check_rb) check($sformatf("r%0d_rb_missing", r), exp_q.size(), 0);
      if (v.mid > 0 && last_cyc >= 10 + v.pre + v.mid)
         check($sformatf("r%0d_stall_hold", r), snap[10 + v.pre + v.mid], snap[10 + v.pre]);
      start      = 1'b0;
      word_valid = 1'b0;
      @(negedge prog_clk);
      check($sformatf("r%0d_idle_after", r), o_state, ST_IDLE);
      check($sformatf("r%0d_done_pulse", r), o_done, 0);
      check($sformatf("r%0d_busy_after", r), o_busy, 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, o_ready, 0);
      check({tag, "_head"},  o_head,  0);
      check({tag, "_en"},    o_en,    0);
      check({tag, "_rbv"},   o_rbv,   0);
      check({tag, "_rb"},    o_rb,    0);
      check({tag, "_busy"},  o_busy,  0);
      check({tag, "_done"},  o_done,  0);
   endtask

   // Start a load, reset it while bit 7 is on the chain head.
   task automatic abort_seq();
      int en_cnt = 0;
      sel = 1'b0;
      @(negedge prog_clk);
      start = 1'b1;
      @(negedge prog_clk);
      start      = 1'b0;
      word_valid = 1'b1;
      word_data  = 8'hA5;
      for (int cyc = 2; cyc < 20 && en_cnt < 7; cyc++) begin
         @(negedge prog_clk);
         word_valid = 1'b0;
         if (o_en) en_cnt++;
      end
      check("abort_reach_bit7", en_cnt, 7);
      pReset_n = 1'b0;
      #1;
      check_all_zero("abort");
      check("abort_state", o_state, ST_IDLE);
      repeat (2) @(negedge prog_clk);
      pReset_n = 1'b1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      vecs[0] = '{1'b0, 8'hA5, 8'h3C, 0, 0, 0, 16, 16'hA53C, 16'hA53C, 1'b1, 8'h00, 8'h00, 1'b0};
      vecs[1] = '{1'b0, 8'hA5, 8'h3C, 0, 0, 0, 16, 16'hA53C, 16'hA53C, 1'b1, 8'hA5, 8'h3C, 1'b0};
      vecs[2] = '{1'b0, 8'hA5, 8'h3C, 0, 3, 0, 16, 16'hA53C, 16'hA53C, 1'b1, 8'hA5, 8'h3C, 1'b0};
      vecs[3] = '{1'b0, 8'h3C, 8'hA5, 3, 0, 3, 16, 16'h3CA5, 16'h3CA5, 1'b1, 8'hA5, 8'h3C, 1'b0};
      vecs[4] = '{1'b1, 8'hA5, 8'h3F, 0, 0, 0, 12, 16'hA530, 16'h0A53, 1'b1, 8'h00, 8'h00, 1'b0};
      vecs[5] = '{1'b1, 8'hA5, 8'h3F, 0, 0, 0, 12, 16'hA530, 16'h0A53, 1'b1, 8'hA5, 8'h30, 1'b0};
      vecs[6] = '{1'b0, 8'h5A, 8'hC3, 0, 0, 0, 16, 16'h5AC3, 16'h5AC3, 1'b0, 8'h00, 8'h00, 1'b1};
      vecs[7] = '{1'b0, 8'hA5, 8'h3C, 0, 0, 0, 16, 16'hA53C, 16'hA53C, 1'b1, 8'h5A, 8'hC3, 1'b0};

      sel        = 1'b0;
      start      = 1'b0;
      word_valid = 1'b0;
      word_data  = '0;
      pReset_n   = 1'b1;
      #2;
      pReset_n = 1'b0;
      #1;
      check_all_zero("reset");
      repeat (3) @(negedge prog_clk);
      pReset_n = 1'b1;
      @(negedge prog_clk);
      check("reset_state_idle", o_state, ST_IDLE);

      // word_valid in IDLE must never handshake
      for (int i = 0; i < 3; i++) begin
         word_valid = 1'b1;
         word_data  = W'($urandom_range(255, 0));
         @(negedge prog_clk);
         check($sformatf("idle_valid_ready%0d", i), o_ready, 0);
         check($sformatf("idle_valid_en%0d", i), o_en, 0);
         check($sformatf("idle_valid_busy%0d", i), o_busy, 0);
      end
      word_valid = 1'b0;

      for (int r = 0; r < 8; r++) begin
         if (vecs[r].abort_before) abort_seq();
         run_vec(r, vecs[r]);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
